// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit: shift-add multiply, restoring divide, HI/LO registers.
// Latency N_BITS+2 edges from start to HI/LO update; busy_o stalls MFHI/MFLO and new ops.
module mult_div_unit #(
  parameter int                N_BITS        = 32,
  parameter logic [N_BITS-1:0] INITIAL_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [N_BITS-1:0] rs_data_i,
  input  logic [N_BITS-1:0] rt_data_i,
  input  logic              hi_we_i,
  input  logic              lo_we_i,
  input  logic [N_BITS-1:0] wdata_i,
  output logic [N_BITS-1:0] hi_o,
  output logic [N_BITS-1:0] lo_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CW = $clog2(N_BITS + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]        state;
  logic [CW-1:0]     count;
  logic              is_div;
  logic              neg_res;
  logic              neg_rem;
  logic              div_zero;
  logic [N_BITS-1:0] rs_save;
  logic [N_BITS-1:0] b_reg;
  logic [N_BITS-1:0] acc;
  logic [N_BITS-1:0] q_reg;

  logic              rs_neg;
  logic              rt_neg;
  logic [N_BITS-1:0] rs_abs;
  logic [N_BITS-1:0] rt_abs;

  logic [N_BITS:0]     mult_sum;
  logic [N_BITS:0]     div_shift;
  logic                div_ge;
  logic [N_BITS-1:0]   div_sub;
  logic [2*N_BITS-1:0] prod_fix;
  logic [N_BITS-1:0]   quot_fix;
  logic [N_BITS-1:0]   rem_fix;

  // op_i[0] selects the signed variants; operands run through the datapath as magnitudes.
  always_comb begin
    rs_neg = op_i[0] & rs_data_i[N_BITS-1];
    rt_neg = op_i[0] & rt_data_i[N_BITS-1];
    rs_abs = rs_neg ? (~rs_data_i + 1'b1) : rs_data_i;
    rt_abs = rt_neg ? (~rt_data_i + 1'b1) : rt_data_i;
  end

  always_comb begin
    mult_sum  = {1'b0, acc} + (q_reg[0] ? {1'b0, b_reg} : {(N_BITS+1){1'b0}});
    div_shift = {acc, q_reg[N_BITS-1]};
    div_ge    = (div_shift >= {1'b0, b_reg});
    // When div_ge holds the difference is below b_reg, so N_BITS bits suffice.
    div_sub   = div_shift[N_BITS-1:0] - b_reg;
    prod_fix  = neg_res ? (~{acc, q_reg} + 1'b1) : {acc, q_reg};
    quot_fix  = neg_res ? (~q_reg + 1'b1) : q_reg;
    rem_fix   = neg_rem ? (~acc + 1'b1) : acc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      rs_save  <= '0;
      b_reg    <= '0;
      acc      <= '0;
      q_reg    <= '0;
      hi_o     <= INITIAL_VALUE;
      lo_o     <= INITIAL_VALUE;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state    <= BUSY;
            count    <= CW'(N_BITS);
            busy_o   <= 1'b1;
            is_div   <= op_i[1];
            neg_res  <= rs_neg ^ rt_neg;
            neg_rem  <= rs_neg;
            div_zero <= op_i[1] & (rt_data_i == '0);
            rs_save  <= rs_data_i;
            acc      <= '0;
            b_reg    <= op_i[1] ? rt_abs : rs_abs;
            q_reg    <= op_i[1] ? rs_abs : rt_abs;
          end else begin
            if (hi_we_i) hi_o <= wdata_i;
            if (lo_we_i) lo_o <= wdata_i;
          end
        end
        BUSY: begin
          if (is_div) begin
            acc   <= div_ge ? div_sub : div_shift[N_BITS-1:0];
            q_reg <= {q_reg[N_BITS-2:0], div_ge};
          end else begin
            acc   <= mult_sum[N_BITS:1];
            q_reg <= {mult_sum[0], q_reg[N_BITS-1:1]};
          end
          count <= count - CW'(1);
          if (count == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (!is_div) begin
            hi_o <= prod_fix[2*N_BITS-1:N_BITS];
            lo_o <= prod_fix[N_BITS-1:0];
          end else if (div_zero) begin
            hi_o <= rs_save;
            lo_o <= '1;
          end else begin
            hi_o <= rem_fix;
            lo_o <= quot_fix;
          end
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed table, random ops vs. arithmetic model, and
// multi-cycle corner sequences (ignored start/strobe mid-op, start in done cycle, reset abort).
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] rs_data_i, rt_data_i, wdata_i;
  logic        hi_we_i, lo_we_i;
  logic [31:0] hi_o, lo_o;
  logic        busy_o, done_o;

  int tests = 0;
  int fails = 0;

  mult_div_unit #(.N_BITS(32), .INITIAL_VALUE(32'h0)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
    .hi_we_i(hi_we_i), .lo_we_i(lo_we_i), .wdata_i(wdata_i),
    .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sp, sq, sr;
    logic [63:0] r;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'b00: r = {32'h0, a} * {32'h0, b};
      2'b01: begin sp = sa * sb; r = sp; end
      2'b10: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          r = {sr[31:0], sq[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b1; op_i = op; rs_data_i = a; rt_data_i = b;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Called at the negedge just after the start edge; lat counts negedges from there.
  task automatic wait_done(output int lat);
    lat = 1;
    while (done_o !== 1'b1 && lat < 80) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run(input string name, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] hi_e, input logic [31:0] lo_e);
    int lat;
    @(negedge clk);
    issue(op, a, b);
    chk({name, " busy"}, 64'(busy_o), 64'd1);
    wait_done(lat);
    // done visible after edge E0+33, i.e. at the 34th negedge after E0
    chk({name, " latency"}, 64'(lat), 64'd34);
    chk({name, " busy at done"}, 64'(busy_o), 64'd0);
    chk({name, " hi"}, 64'(hi_o), 64'(hi_e));
    chk({name, " lo"}, 64'(lo_o), 64'(lo_e));
    @(negedge clk);
    chk({name, " done width"}, 64'(done_o), 64'd0);
  endtask

  initial begin
    int lat;
    int seen;
    logic [63:0] e;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    vecs[0] = '{"multu_max",   2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{"mult_m3x7",   2'b01, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{"mult_minsq",  2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[3] = '{"div_m7d2",    2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4] = '{"divu_100d7",  2'b10, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[5] = '{"divu_by0",    2'b10, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF};
    vecs[6] = '{"div_min_m1",  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[7] = '{"div_m7_by0",  2'b11, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};

    reset = 1'b0; start_i = 1'b0; op_i = 2'b00; rs_data_i = '0; rt_data_i = '0;
    hi_we_i = 1'b0; lo_we_i = 1'b0; wdata_i = '0;
    repeat (2) @(negedge clk);
    chk("reset hi", 64'(hi_o), 64'd0);
    chk("reset lo", 64'(lo_o), 64'd0);
    chk("reset busy", 64'(busy_o), 64'd0);
    chk("reset done", 64'(done_o), 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 8; i++)
      run(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom_range(0, 15);
        1: rb = -$urandom_range(1, 15);
        2: rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      if (i % 5 == 0) ra = $urandom_range(0, 300);
      e = model(rop, ra, rb);
      run($sformatf("rand%0d", i), rop, ra, rb, e[63:32], e[31:0]);
    end

    // MTHI/MTLO in IDLE
    @(negedge clk);
    hi_we_i = 1'b1; wdata_i = 32'hAAAA_0001;
    @(negedge clk);
    hi_we_i = 1'b0; lo_we_i = 1'b1; wdata_i = 32'hBBBB_0002;
    @(negedge clk);
    lo_we_i = 1'b0;
    chk("mthi hi", 64'(hi_o), 64'hAAAA_0001);
    chk("mtlo lo", 64'(lo_o), 64'hBBBB_0002);
    hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = 32'h1111_2222;
    @(negedge clk);
    hi_we_i = 1'b0; lo_we_i = 1'b0;
    chk("mt both hi", 64'(hi_o), 64'h1111_2222);
    chk("mt both lo", 64'(lo_o), 64'h1111_2222);

    // start with a strobe: write dropped, HI/LO untouched while busy
    hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
    issue(2'b01, 32'hFFFF_FFFD, 32'd7);
    hi_we_i = 1'b0; lo_we_i = 1'b0;
    repeat (8) @(negedge clk);
    chk("start beats strobe hi", 64'(hi_o), 64'h1111_2222);
    chk("no partial lo", 64'(lo_o), 64'h1111_2222);
    // cycle 10: new start plus MTHI while busy, both ignored
    start_i = 1'b1; op_i = 2'b00; rs_data_i = 32'd5; rt_data_i = 32'd9;
    hi_we_i = 1'b1; wdata_i = 32'hCAFE_0000;
    @(negedge clk);
    start_i = 1'b0; hi_we_i = 1'b0;
    chk("busy mthi ignored", 64'(hi_o), 64'h1111_2222);
    wait_done(lat);
    chk("busy start done", 64'(done_o), 64'd1);
    chk("busy start hi", 64'(hi_o), 64'hFFFF_FFFF);
    chk("busy start lo", 64'(lo_o), 64'hFFFF_FFEB);

    // start in the done cycle
    issue(2'b10, 32'd100, 32'd7);
    chk("done-cycle start busy", 64'(busy_o), 64'd1);
    wait_done(lat);
    chk("done-cycle start latency", 64'(lat), 64'd34);
    chk("done-cycle start hi", 64'(hi_o), 64'd2);
    chk("done-cycle start lo", 64'(lo_o), 64'd14);

    // reset at cycle 15 of a DIV
    @(negedge clk);
    issue(2'b11, 32'hFFFF_FF9C, 32'd7);
    repeat (14) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort hi", 64'(hi_o), 64'd0);
    chk("abort lo", 64'(lo_o), 64'd0);
    chk("abort busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o === 1'b1) seen++;
    end
    chk("abort no done", 64'(seen), 64'd0);
    chk("abort hi held", 64'(hi_o), 64'd0);
    e = model(2'b11, 32'hFFFF_FF9C, 32'd7);
    run("after abort div", 2'b11, 32'hFFFF_FF9C, 32'd7, e[63:32], e[31:0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
